// File: rtl/trigger_process_mc.sv
// trigger_process_mc: qualifies one external trigger and emits a camera/core burst plus CH_NUM delayed external pulses.
// Latency: qualified edge SYNC_STAGES+1 clocks after trigger_in; first camera edge E+1+delay; channel active core+1+delay[k].
// No backpressure: edges that arrive mid-burst are dropped and counted; trigger_out_en/reg_ch_enable low abort on the next clock.
module trigger_process_mc #(
  parameter int CH_NUM      = 4,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    trigger_in,
  input  logic                    trigger_out_en,
  input  logic [1:0]              reg_edge_sel,
  input  logic [CNT_W-1:0]        reg_camera_delay,
  input  logic [CNT_W-1:0]        reg_camera_cycle,
  input  logic [CNT_W-1:0]        reg_camera_width,
  input  logic [CNT_W-1:0]        reg_camera_trig_num,
  input  logic [CH_NUM-1:0]       reg_ch_enable,
  input  logic [CH_NUM-1:0]       reg_ch_polar,
  input  logic [CH_NUM*CNT_W-1:0] reg_ch_delay,
  input  logic [CH_NUM*CNT_W-1:0] reg_ch_width,
  output logic                    trigger_camera,
  output logic                    trigger_core,
  output logic [CH_NUM-1:0]       trigger_external,
  output logic                    busy,
  output logic                    burst_done,
  output logic [15:0]             trig_in_cnt,
  output logic [15:0]             trig_miss_cnt
);

  localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO = CNT_W'(2);

  localparam logic [1:0] M_IDLE  = 2'd0;
  localparam logic [1:0] M_DELAY = 2'd1;
  localparam logic [1:0] M_PULSE = 2'd2;
  localparam logic [1:0] M_GAP   = 2'd3;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_DLY  = 2'd1;
  localparam logic [1:0] C_ACT  = 2'd2;

  // ---------------- input qualification ----------------
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge;
  logic                   w_sync;
  logic                   w_edge;

  assign w_sync = r_sync[SYNC_STAGES-1];

  // Edge selection on the synchronised input; 11 never qualifies.
  always_comb begin
    w_edge = 1'b0;
    case (reg_edge_sel)
      2'b00:   w_edge = w_sync & ~r_prev;
      2'b01:   w_edge = ~w_sync & r_prev;
      2'b10:   w_edge = w_sync ^ r_prev;
      default: w_edge = 1'b0;
    endcase
  end

  // Synchroniser chain plus the registered edge pulse E.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], trigger_in};
      r_prev <= w_sync;
      r_edge <= w_edge;
    end
  end

  // ---------------- master burst FSM ----------------
  logic [1:0]              r_mst, w_mst_nxt;
  logic [CNT_W-1:0]        r_cnt, r_pcnt;
  logic                    r_cam, r_core, r_busy, r_done;
  logic                    w_cam_nxt, w_core_nxt, w_busy_nxt, w_done_nxt;
  logic                    w_accept, w_enter_pulse;
  logic [CNT_W-1:0]        r_sh_delay, r_sh_cycle, r_sh_width, r_sh_num;
  logic [CH_NUM-1:0]       r_sh_ch_en, r_sh_ch_pol;
  logic [CH_NUM*CNT_W-1:0] r_sh_ch_dly, r_sh_ch_wid;
  logic [CNT_W-1:0]        w_cyc_eff, w_wid_max, w_wid_eff, w_gap_len;

  // Period is at least 2 so there is always one low cycle; width lands in [1, period-1].
  assign w_cyc_eff = (r_sh_cycle < C_TWO) ? C_TWO : r_sh_cycle;
  assign w_wid_max = w_cyc_eff - C_ONE;
  assign w_wid_eff = (r_sh_width == '0) ? C_ONE :
                     ((r_sh_width > w_wid_max) ? w_wid_max : r_sh_width);
  assign w_gap_len = w_cyc_eff - w_wid_eff;

  // Shadows are not loaded yet in the accept cycle, so the live registers decide acceptance and delay skip.
  assign w_accept = r_edge & trigger_out_en & (r_mst == M_IDLE) & (reg_camera_trig_num != '0);

  // Next-state logic; disable wins over everything.
  always_comb begin
    w_mst_nxt = r_mst;
    if (!trigger_out_en) begin
      w_mst_nxt = M_IDLE;
    end else begin
      case (r_mst)
        M_IDLE:  if (w_accept) w_mst_nxt = (reg_camera_delay == '0) ? M_PULSE : M_DELAY;
        M_DELAY: if (r_cnt == r_sh_delay - C_ONE) w_mst_nxt = M_PULSE;
        M_PULSE: if (r_cnt == w_wid_eff - C_ONE) w_mst_nxt = M_GAP;
        default: if (r_cnt == w_gap_len - C_ONE) w_mst_nxt = (r_pcnt == r_sh_num) ? M_IDLE : M_PULSE;
      endcase
    end
  end

  // Output decode from the next state so every output comes straight off a flop.
  always_comb begin
    w_enter_pulse = (w_mst_nxt == M_PULSE) && (r_mst != M_PULSE);
    w_cam_nxt     = (w_mst_nxt == M_PULSE);
    w_core_nxt    = w_enter_pulse;
    w_busy_nxt    = (w_mst_nxt != M_IDLE);
    w_done_nxt    = (r_mst == M_GAP) && (w_mst_nxt == M_IDLE) && trigger_out_en;
  end

  // Master state, phase counter, pulse counter and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mst  <= M_IDLE;
      r_cnt  <= '0;
      r_pcnt <= '0;
      r_cam  <= 1'b0;
      r_core <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_mst <= w_mst_nxt;
      r_cnt <= ((w_mst_nxt != r_mst) || (r_mst == M_IDLE)) ? '0 : r_cnt + C_ONE;
      if (w_enter_pulse)
        r_pcnt <= (r_mst == M_IDLE) ? C_ONE : r_pcnt + C_ONE;
      else if (r_mst == M_IDLE)
        r_pcnt <= '0;
      r_cam  <= w_cam_nxt;
      r_core <= w_core_nxt;
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  // Shadow copies taken in the accept cycle; mid-burst register writes wait for the next burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh_delay  <= '0;
      r_sh_cycle  <= '0;
      r_sh_width  <= '0;
      r_sh_num    <= '0;
      r_sh_ch_en  <= '0;
      r_sh_ch_pol <= '0;
      r_sh_ch_dly <= '0;
      r_sh_ch_wid <= '0;
    end else if (w_accept) begin
      r_sh_delay  <= reg_camera_delay;
      r_sh_cycle  <= reg_camera_cycle;
      r_sh_width  <= reg_camera_width;
      r_sh_num    <= reg_camera_trig_num;
      r_sh_ch_en  <= reg_ch_enable;
      r_sh_ch_pol <= reg_ch_polar;
      r_sh_ch_dly <= reg_ch_delay;
      r_sh_ch_wid <= reg_ch_width;
    end
  end

  // Saturating statistics: every qualified edge, and edges lost to an active burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      trig_in_cnt   <= '0;
      trig_miss_cnt <= '0;
    end else begin
      if (r_edge && (trig_in_cnt != 16'hFFFF))
        trig_in_cnt <= trig_in_cnt + 16'd1;
      if (r_edge && r_busy && (trig_miss_cnt != 16'hFFFF))
        trig_miss_cnt <= trig_miss_cnt + 16'd1;
    end
  end

  assign trigger_camera = r_cam;
  assign trigger_core   = r_core;
  assign busy           = r_busy;
  assign burst_done     = r_done;

  // ---------------- per-channel FSMs ----------------
  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [1:0]       r_st, w_st_nxt;
    logic [CNT_W-1:0] r_ccnt;
    logic             r_act, w_act_nxt;
    logic             w_pol;
    logic [CNT_W-1:0] w_dly, w_wid;

    assign w_dly = r_sh_ch_dly[k*CNT_W +: CNT_W];
    assign w_wid = r_sh_ch_wid[k*CNT_W +: CNT_W];

    // Channel next state; core pulses arriving while DLY/ACT are ignored.
    always_comb begin
      w_st_nxt = r_st;
      if (!trigger_out_en || !reg_ch_enable[k]) begin
        w_st_nxt = C_IDLE;
      end else begin
        case (r_st)
          C_IDLE:  if (r_core && r_sh_ch_en[k] && (w_wid != '0)) w_st_nxt = (w_dly == '0) ? C_ACT : C_DLY;
          C_DLY:   if (r_ccnt == w_dly - C_ONE) w_st_nxt = C_ACT;
          C_ACT:   if (r_ccnt == w_wid - C_ONE) w_st_nxt = C_IDLE;
          default: w_st_nxt = C_IDLE;
        endcase
      end
    end

    // Channel output decode.
    always_comb begin
      w_act_nxt = (w_st_nxt == C_ACT);
    end

    // Channel state, counter and registered active flag.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_st   <= C_IDLE;
        r_ccnt <= '0;
        r_act  <= 1'b0;
      end else begin
        r_st   <= w_st_nxt;
        r_ccnt <= ((w_st_nxt != r_st) || (r_st == C_IDLE)) ? '0 : r_ccnt + C_ONE;
        r_act  <= w_act_nxt;
      end
    end

    // Idle level follows the live polarity; during a burst the latched polarity holds.
    assign w_pol = (r_busy || (r_st != C_IDLE)) ? r_sh_ch_pol[k] : reg_ch_polar[k];
    assign trigger_external[k] = r_act ^ w_pol;
  end

endmodule
